// File: rtl/mac_feeder.sv
// mac_feeder: sequencing front end for a 4-lane dot-product wrapper.
//
// Accepts 4-element activation/weight groups on a valid/ready input and holds
// each one in a single stage (S1). From S1 it drives the wrapper's x/w lanes and
// the running partial sum. The wrapper's combinational sum (mac_out) is captured
// back into the accumulator, or into the result slot for the last group of a
// vector. This block does no arithmetic itself.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     group handshake; in_last marks the last group of a vector
//   x_in, w_in            packed lanes, lane i at [Bw*i +: Bw]
//   mac_x, mac_w          to wrapper x0..x3 / w0..w3 (registered S1 contents)
//   mac_psum              to wrapper psum_in (accumulator)
//   mac_out               from wrapper out, same cycle
//   out_valid/out_ready   result handshake
//   out_data, out_cnt     vector sum and number of groups summed into it
//   err                   sticky: a vector ran past MaxGrp groups and was cut
module mac_feeder #(
    parameter int unsigned Bw     = 4,
    parameter int unsigned PsumBw = 16,
    parameter int unsigned MaxGrp = 16,
    parameter int unsigned CntW   = $clog2(MaxGrp) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4*Bw-1:0]   x_in,
    input  logic [4*Bw-1:0]   w_in,
    output logic [4*Bw-1:0]   mac_x,
    output logic [4*Bw-1:0]   mac_w,
    output logic [PsumBw-1:0] mac_psum,
    input  logic [PsumBw-1:0] mac_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PsumBw-1:0] out_data,
    output logic [CntW-1:0]   out_cnt,
    output logic              err
);

    localparam logic [CntW-1:0] OneCnt = CntW'(1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxGrp);

    logic              r_s1_valid;
    logic              r_s1_last;
    logic [4*Bw-1:0]   r_x;
    logic [4*Bw-1:0]   r_w;
    logic [PsumBw-1:0] r_acc;
    logic [CntW-1:0]   r_grp_cnt;
    logic              r_out_valid;
    logic [PsumBw-1:0] r_out_data;
    logic [CntW-1:0]   r_out_cnt;
    logic              r_err;

    logic              w_s1_fire;
    logic              w_in_fire;
    logic [CntW-1:0]   w_grp_idx;
    logic              w_force_last;

    // A last group may only leave S1 if the result slot is free or draining.
    assign w_s1_fire = r_s1_valid && (!r_s1_last || !r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s1_fire;
    assign w_in_fire = in_valid && in_ready;

    // Position of the incoming group within its vector. A group still sitting
    // in S1 has not been counted in r_grp_cnt yet, so account for it here; if
    // it is a last group, the incoming one starts a fresh vector.
    always_comb begin
        w_grp_idx = r_grp_cnt;
        if (r_s1_valid) begin
            w_grp_idx = r_s1_last ? '0 : r_grp_cnt + OneCnt;
        end
    end

    assign w_force_last = ((w_grp_idx + OneCnt) == MaxCnt) && !in_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_x         <= '0;
            r_w         <= '0;
            r_acc       <= '0;
            r_grp_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            // S1 load / drain
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= in_last || w_force_last;
                r_x        <= x_in;
                r_w        <= w_in;
                if (w_force_last) begin
                    r_err <= 1'b1;
                end
            end else if (w_s1_fire) begin
                r_s1_valid <= 1'b0;
            end

            // Retire S1 into the accumulator or the result slot
            if (w_s1_fire) begin
                if (r_s1_last) begin
                    r_out_data <= mac_out;
                    r_out_cnt  <= r_grp_cnt + OneCnt;
                    r_acc      <= '0;
                    r_grp_cnt  <= '0;
                end else begin
                    r_acc     <= mac_out;
                    r_grp_cnt <= r_grp_cnt + OneCnt;
                end
            end

            // A new result loading wins over the consumer draining the slot.
            if (w_s1_fire && r_s1_last) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign mac_x     = r_x;
    assign mac_w     = r_w;
    assign mac_psum  = r_acc;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder. Two instances: u_a (16-bit psum, 4 groups max)
// covers the main sequencing and the group-limit cut; u_b (8-bit psum, 32 groups
// max) covers accumulator wrap. Each instance is closed by a behavioural model
// of the dot-product wrapper: out = psum_in + sum(x_i * w_i), truncated.
module tb_mac_feeder;

    logic clk;
    logic reset_n;

    // Instance A
    logic        a_in_valid, a_in_ready, a_in_last;
    logic [15:0] a_x_in, a_w_in, a_mac_x, a_mac_w;
    logic [15:0] a_mac_psum, a_mac_out, a_out_data;
    logic        a_out_valid, a_out_ready, a_err;
    logic [2:0]  a_out_cnt;

    // Instance B
    logic        b_in_valid, b_in_ready, b_in_last;
    logic [15:0] b_x_in, b_w_in, b_mac_x, b_mac_w;
    logic [7:0]  b_mac_psum, b_mac_out, b_out_data;
    logic        b_out_valid, b_out_ready, b_err;
    logic [5:0]  b_out_cnt;

    int n_checks = 0;
    int n_err    = 0;

    mac_feeder #(.Bw(4), .PsumBw(16), .MaxGrp(4)) u_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_last   (a_in_last),
        .x_in      (a_x_in),
        .w_in      (a_w_in),
        .mac_x     (a_mac_x),
        .mac_w     (a_mac_w),
        .mac_psum  (a_mac_psum),
        .mac_out   (a_mac_out),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_cnt   (a_out_cnt),
        .err       (a_err)
    );

    mac_feeder #(.Bw(4), .PsumBw(8), .MaxGrp(32)) u_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_last   (b_in_last),
        .x_in      (b_x_in),
        .w_in      (b_w_in),
        .mac_x     (b_mac_x),
        .mac_w     (b_mac_w),
        .mac_psum  (b_mac_psum),
        .mac_out   (b_mac_out),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_cnt   (b_out_cnt),
        .err       (b_err)
    );

    function automatic int dot4(input logic [15:0] x, input logic [15:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'(x[4*i +: 4]) * int'(w[4*i +: 4]);
        end
        return s;
    endfunction

    always_comb a_mac_out = 16'(int'(a_mac_psum) + dot4(a_mac_x, a_mac_w));
    always_comb b_mac_out = 8'(int'(b_mac_psum) + dot4(b_mac_x, b_mac_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one group to A, wait (bounded) for acceptance, return at edge+1.
    task automatic a_push(input logic [15:0] x, input logic [15:0] w, input logic last);
        int n;
        a_in_valid = 1'b1;
        a_x_in     = x;
        a_w_in     = w;
        a_in_last  = last;
        #1;
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_in_ready_wait", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_push(input logic [15:0] x, input logic [15:0] w, input logic last);
        int n;
        b_in_valid = 1'b1;
        b_x_in     = x;
        b_w_in     = w;
        b_in_last  = last;
        #1;
        n = 0;
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) chk("b_in_ready_wait", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        a_in_valid  = 1'b0;
        a_in_last   = 1'b0;
        a_x_in      = '0;
        a_w_in      = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_last   = 1'b0;
        b_x_in      = '0;
        b_w_in      = '0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_mac_x", {16'd0, a_mac_x}, 32'd0);
        chk("rst_mac_w", {16'd0, a_mac_w}, 32'd0);
        chk("rst_mac_psum", {16'd0, a_mac_psum}, 32'd0);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, a_out_data}, 32'd0);
        chk("rst_out_cnt", {29'd0, a_out_cnt}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single group 1,2,3,4 . 1,1,1,1 = 10
        a_push(16'h4321, 16'h1111, 1'b1);
        chk("t1_s1_mac_x", {16'd0, a_mac_x}, 32'h4321);
        chk("t1_s1_psum", {16'd0, a_mac_psum}, 32'd0);
        chk("t1_early_valid", {31'd0, a_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t1_out_data", {16'd0, a_out_data}, 32'd10);
        chk("t1_out_cnt", {29'd0, a_out_cnt}, 32'd1);
        chk("t1_acc_clear", {16'd0, a_mac_psum}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_valid_drop", {31'd0, a_out_valid}, 32'd0);

        // 3 groups of 2*3 per lane (24 each) = 72, then a fresh 1-group vector = 4
        a_push(16'h2222, 16'h3333, 1'b0);
        a_push(16'h2222, 16'h3333, 1'b0);
        chk("t2_acc_mid", {16'd0, a_mac_psum}, 32'd24);
        a_push(16'h2222, 16'h3333, 1'b1);
        chk("t2_acc_mid2", {16'd0, a_mac_psum}, 32'd48);
        a_push(16'h1111, 16'h1111, 1'b1);
        chk("t2_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t2_out_data", {16'd0, a_out_data}, 32'd72);
        chk("t2_out_cnt", {29'd0, a_out_cnt}, 32'd3);
        chk("t2_next_psum0", {16'd0, a_mac_psum}, 32'd0);
        @(posedge clk);
        #1;
        chk("t2b_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t2b_out_data", {16'd0, a_out_data}, 32'd4);
        chk("t2b_out_cnt", {29'd0, a_out_cnt}, 32'd1);
        @(posedge clk);
        #1;
        chk("t2_valid_drop", {31'd0, a_out_valid}, 32'd0);

        // Back-pressure: results 10 and 20 with out_ready low
        a_out_ready = 1'b0;
        a_push(16'h4321, 16'h1111, 1'b1);
        a_push(16'h8642, 16'h1111, 1'b1);
        chk("t3_hold_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t3_hold_data", {16'd0, a_out_data}, 32'd10);
        chk("t3_stall_ready", {31'd0, a_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("t3_hold_data2", {16'd0, a_out_data}, 32'd10);
        chk("t3_hold_cnt", {29'd0, a_out_cnt}, 32'd1);
        chk("t3_stall_ready2", {31'd0, a_in_ready}, 32'd0);
        chk("t3_s1_kept", {16'd0, a_mac_x}, 32'h8642);
        a_out_ready = 1'b1;
        #1;
        chk("t3_ready_comb", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t3_second_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t3_second_data", {16'd0, a_out_data}, 32'd20);
        @(posedge clk);
        #1;
        chk("t3_valid_drop", {31'd0, a_out_valid}, 32'd0);

        // Group limit: 5 non-last groups with MaxGrp = 4
        a_push(16'h1111, 16'h1111, 1'b0);
        a_push(16'h1111, 16'h1111, 1'b0);
        a_push(16'h1111, 16'h1111, 1'b0);
        chk("t4_err_before", {31'd0, a_err}, 32'd0);
        a_push(16'h1111, 16'h1111, 1'b0);
        chk("t4_err_set", {31'd0, a_err}, 32'd1);
        a_push(16'h1111, 16'h1111, 1'b0);
        chk("t4_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t4_out_data", {16'd0, a_out_data}, 32'd16);
        chk("t4_out_cnt", {29'd0, a_out_cnt}, 32'd4);
        chk("t4_new_vec_psum", {16'd0, a_mac_psum}, 32'd0);
        @(posedge clk);
        #1;
        chk("t4_fifth_acc", {16'd0, a_mac_psum}, 32'd4);
        chk("t4_fifth_not_out", {31'd0, a_out_valid}, 32'd0);
        chk("t4_err_sticky", {31'd0, a_err}, 32'd1);

        // Accumulator wrap on B: 20 groups of 900 mod 256 = 80
        for (int g = 0; g < 19; g++) begin
            b_push(16'hFFFF, 16'hFFFF, 1'b0);
        end
        b_push(16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        chk("t5_out_valid", {31'd0, b_out_valid}, 32'd1);
        chk("t5_out_data", {24'd0, b_out_data}, 32'd80);
        chk("t5_out_cnt", {26'd0, b_out_cnt}, 32'd20);
        chk("t5_err", {31'd0, b_err}, 32'd0);

        // Reset mid-vector on A (partial acc 4 from the fifth group above)
        a_push(16'h1111, 16'h1111, 1'b0);
        a_push(16'h1111, 16'h1111, 1'b0);
        chk("t6_mid_acc", {16'd0, a_mac_psum}, 32'd8);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_psum", {16'd0, a_mac_psum}, 32'd0);
        chk("t6_rst_err", {31'd0, a_err}, 32'd0);
        chk("t6_rst_ready", {31'd0, a_in_ready}, 32'd1);
        chk("t6_rst_mac_x", {16'd0, a_mac_x}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        a_push(16'h1111, 16'h1111, 1'b1);
        @(posedge clk);
        #1;
        chk("t6_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t6_out_data", {16'd0, a_out_data}, 32'd4);
        chk("t6_out_cnt", {29'd0, a_out_cnt}, 32'd1);
        chk("t6_err", {31'd0, a_err}, 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Sequencing front end for the 4-lane dot-product wrapper: accepts a stream of 4-element activation/weight groups, drives the wrapper's x0..x3, w0..w3 and psum_in ports, and closes the partial-sum loop by capturing the wrapper's combinational sum back into an accumulator. One vector is a run of one or more groups terminated by in_last. Its sum is presented on a valid/ready result port. Sits between the activation/weight SRAM readers and the output/psum buffer.

## Interface
- bw, 4, activation/weight element width (matches wrapper)
- psum_bw, 16, partial-sum width (matches wrapper)
- max_grp, 16, maximum groups per vector; cnt width = clog2(max_grp)+1
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  group available
- in_ready  out  1  group accepted when in_valid && in_ready
- in_last  in  1  group is last of vector
- x_in  in  4*bw  packed x[3..0], lane i at [bw*i +: bw]
- w_in  in  4*bw  packed w[3..0], same packing
- mac_x  out  4*bw  to wrapper x0..x3 (lane i -> xi)
- mac_w  out  4*bw  to wrapper w0..w3
- mac_psum  out  psum_bw  to wrapper psum_in
- mac_out  in  psum_bw  from wrapper out (combinational, same cycle)
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  psum_bw  vector sum
- out_cnt  out  cnt width  groups summed into out_data
- err  out  1  sticky: vector exceeded max_grp groups

## Operation
- Stage S1 registers: s1_valid, s1_last, x_q, w_q. mac_x = x_q, mac_w = w_q, mac_psum = acc_q. No arithmetic in this block; all sums come from mac_out, wrap modulo 2^psum_bw.
- Input fire loads S1 with x_in, w_in, in_last. If grp_cnt+1 == max_grp and in_last = 0, the group is forced last and err sets (sticky until reset).
- s1_fire = s1_valid && (!s1_last || !out_valid || out_ready).
- On s1_fire, non-last: acc_q <= mac_out; grp_cnt <= grp_cnt+1.
- On s1_fire, last: out_data <= mac_out; out_cnt <= grp_cnt+1; out_valid <= 1; acc_q <= 0; grp_cnt <= 0.
- in_ready = !s1_valid || s1_fire. s1_valid <= in fire, else cleared on s1_fire.
- Output: out_valid clears on out fire unless a new result loads the same cycle (load wins, no bubble). out_data/out_cnt stable while out_valid && !out_ready.
- States implied: IDLE (s1 empty, acc 0), ACCUM (acc nonzero-run in progress), HOLD (last group in S1, result slot full, out_ready low -> S1 and in_ready stall).
- Reset (any time, including mid-vector): s1_valid, out_valid, err = 0; acc_q, grp_cnt, out_data, out_cnt, x_q, w_q = 0; partial vector discarded. Outputs after reset: in_ready = 1, mac_* = 0, out_* = 0, err = 0.

## Timing
- Throughput one group per cycle with out_ready held high; no bubbles between vectors.
- Latency: group accepted at edge t -> in S1 after t -> result registered at edge t+1 -> out_valid high in cycle after t+1 (2 edges from input fire to out_valid for a single-group vector; N-group vector: 2 edges after its last group fires).
- Back-to-back vectors: acc_q clears in the same edge the last group retires, so next vector's first group in S1 sees mac_psum = 0.
- Result slot full and out_ready low: non-last groups still retire; a last group stalls in S1 and in_ready drops combinationally.
- in_ready depends combinationally on out_ready; out_valid/out_data are registered.

## Test plan
- Single group x=1,2,3,4 w=1,1,1,1 last=1 -> out_valid 2 edges later, out_data=10, out_cnt=1, acc returns to 0.
- Vector of 3 groups, all x=2 w=3 back-to-back -> one result out_data=72, out_cnt=3; following vector x=1 w=1 single group -> 4 (no carry-over).
- out_ready low, two 1-group vectors (sums 10, 20) streamed -> first held as 10, second stalls in S1, in_ready=0; raise out_ready -> 10 then 20 on consecutive cycles.
- max_grp=4, feed 5 groups x=1 w=1 with in_last never set -> result 16, out_cnt=4 after fourth group, err=1 and stays 1; fifth group starts new vector.
- Accumulator wrap: psum_bw=8, 20 groups x=15 w=15 (max_grp>=20) -> out_data=(20*900) mod 256 = 80.
- Assert reset_n low mid-vector after 2 of 3 groups, then release and send 1 group x=1,1,1,1 w=1,1,1,1 last -> out_data=4, out_cnt=1, no stale partial sum, err=0.
